// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// One transaction in flight: accept (IDLE), let the ALU settle (EXEC), hold the response (RESP).
module alu_arbiter #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [3:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [3:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic [3:0]        alu_op,
  output logic [DATA_W-1:0] alu_first,
  output logic [DATA_W-1:0] alu_second,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  logic   owner;
  logic   last_grant;
  logic   grant_valid;
  logic   grant_idx;
  logic   accept;
  logic   rsp_hs;

  // When both requesters contend, the one not served last time wins.
  always_comb begin : arbitrate
    // NOTE: defaults first so every path assigns both signals; otherwise a latch is inferred.
    grant_valid = 1'b0;
    grant_idx   = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_valid = 1'b1;
      grant_idx   = ~last_grant;
    end else if (req0_valid) begin
      grant_valid = 1'b1;
    end else if (req1_valid) begin
      grant_valid = 1'b1;
      grant_idx   = 1'b1;
    end
  end

  // Gating with rst keeps both readies low while reset is held, even if requesters are valid.
  assign accept     = rst && (state == IDLE) && grant_valid;
  assign req0_ready = accept && !grant_idx;
  assign req1_ready = accept && grant_idx;

  // Only the owner's ready completes a response; the other requester's ready is ignored.
  assign rsp_hs     = (state == RESP) && (owner ? rsp1_ready : rsp0_ready);
  assign rsp0_valid = (state == RESP) && !owner;
  assign rsp1_valid = (state == RESP) && owner;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      alu_op     <= '0;
      alu_first  <= '0;
      alu_second <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values regardless of order.
      case (state)
        IDLE: begin
          if (accept) begin
            alu_op     <= grant_idx ? req1_op : req0_op;
            alu_first  <= grant_idx ? req1_a  : req0_a;
            alu_second <= grant_idx ? req1_b  : req0_b;
            owner      <= grant_idx;
            last_grant <= grant_idx;
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= alu_result;
          rsp_zero   <= alu_zero;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_hs) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of arbitration and ALU results.
module tb_alu_arbiter;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]   req0_op, req1_op;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [W-1:0] rsp_result;
  logic         rsp_zero;
  logic [3:0]   alu_op;
  logic [W-1:0] alu_first, alu_second, alu_result;
  logic         alu_zero;
  logic         busy;

  int errors = 0;
  int checks = 0;
  int m_last = 1;  // model: index granted most recently

  always #5 clk = ~clk;

  // Reference ALU behaviour; unsupported op codes return a recognisable pattern.
  function automatic logic [W-1:0] alu_fn(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    case (op)
      4'd0:    r = a + b;
      4'd1:    r = a - b;
      4'd2:    r = a & b;
      4'd3:    r = a | b;
      4'd4:    r = ~a;
      4'd5:    r = $signed(a) >>> b[3:0];
      4'd6:    r = a << b[3:0];
      4'd7:    r = {15'd0, $signed(a) < $signed(b)};
      4'd8:    r = '0;
      4'd9:    r = a;
      4'd10:   r = {15'd0, a == '0};
      4'd11:   r = {15'd0, a != b};
      4'd12:   r = b;
      default: r = 16'hBAD0 ^ {12'd0, op};
    endcase
    return r;
  endfunction

  assign alu_result = alu_fn(alu_op, alu_first, alu_second);
  assign alu_zero   = (alu_result == '0);

  alu_arbiter #(.DATA_W(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .alu_op(alu_op), .alu_first(alu_first), .alu_second(alu_second),
    .alu_result(alu_result), .alu_zero(alu_zero), .busy(busy)
  );

  task automatic clear_inputs();
    req0_valid = 0; req0_op = '0; req0_a = '0; req0_b = '0;
    req1_valid = 0; req1_op = '0; req1_a = '0; req1_b = '0;
    rsp0_ready = 0; rsp1_ready = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst = 1;
    m_last = 1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_drain: busy=%0b still set after %0d cycles, expected 0", name, busy, n);
    end
    rsp0_ready = 0; rsp1_ready = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 0;
    clear_inputs();
    req0_valid = 1; req1_valid = 1;
    #1;
    checks++;
    if ({busy, rsp0_valid, rsp1_valid, req0_ready, req1_ready, rsp_zero} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy,rsp0v,rsp1v,rdy0,rdy1,zero=%b expected 000000",
               {busy, rsp0_valid, rsp1_valid, req0_ready, req1_ready, rsp_zero});
    end
    checks++;
    if ({alu_op, alu_first, alu_second, rsp_result} !== '0) begin
      errors++;
      $display("FAIL reset_data: op=%h first=%h second=%h result=%h expected all 0",
               alu_op, alu_first, alu_second, rsp_result);
    end
    @(negedge clk);
    rst = 1;
    m_last = 1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++;
      $display("FAIL reset_first_grant: rdy0,rdy1=%b expected 10", {req0_ready, req1_ready});
    end
    clear_inputs();
  endtask

  task automatic test_single();
    @(negedge clk);
    req0_valid = 1; req0_op = 4'b0000; req0_a = 16'h0003; req0_b = 16'h0004;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++;
      $display("FAIL single_ready: rdy0,rdy1=%b expected 10", {req0_ready, req1_ready});
    end
    @(posedge clk);
    m_last = 0;
    @(negedge clk);
    req0_valid = 0;
    checks++;
    if ({alu_op, alu_first, alu_second} !== {4'b0000, 16'h0003, 16'h0004} || busy !== 1'b1 || rsp0_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_exec: op=%h first=%h second=%h busy=%0b rsp0v=%0b expected 0/0003/0004/1/0",
               alu_op, alu_first, alu_second, busy, rsp0_valid);
    end
    @(negedge clk);
    checks++;
    if ({rsp0_valid, rsp1_valid, rsp_zero} !== 3'b100 || rsp_result !== 16'h0007) begin
      errors++;
      $display("FAIL single_rsp: rsp0v,rsp1v,zero=%b result=%h expected 100 / 0007",
               {rsp0_valid, rsp1_valid, rsp_zero}, rsp_result);
    end
    rsp0_ready = 1;
    @(negedge clk);
    rsp0_ready = 0;
    checks++;
    if (busy !== 1'b0 || rsp0_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_done: busy=%0b rsp0v=%0b expected 0 0", busy, rsp0_valid);
    end
  endtask

  task automatic test_both_after_reset();
    do_reset();
    req0_valid = 1; req0_op = 4'b0001; req0_a = 16'h0005; req0_b = 16'h0005;
    req1_valid = 1; req1_op = 4'b0011; req1_a = 16'h00F0; req1_b = 16'h000F;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++;
      $display("FAIL both_first_grant: rdy0,rdy1=%b expected 10", {req0_ready, req1_ready});
    end
    @(posedge clk);
    @(negedge clk);
    req0_valid = 0;
    @(negedge clk);
    checks++;
    if ({rsp0_valid, rsp1_valid, rsp_zero} !== 3'b101 || rsp_result !== 16'h0000) begin
      errors++;
      $display("FAIL both_rsp0: rsp0v,rsp1v,zero=%b result=%h expected 101 / 0000",
               {rsp0_valid, rsp1_valid, rsp_zero}, rsp_result);
    end
    rsp0_ready = 1;
    checks++;
    if (req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL both_no_accept_in_hs: rdy1=%0b expected 0", req1_ready);
    end
    @(negedge clk);
    rsp0_ready = 0;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      errors++;
      $display("FAIL both_second_grant: rdy0,rdy1=%b expected 01", {req0_ready, req1_ready});
    end
    @(posedge clk);
    @(negedge clk);
    req1_valid = 0;
    @(negedge clk);
    checks++;
    if ({rsp0_valid, rsp1_valid, rsp_zero} !== 3'b010 || rsp_result !== 16'h00FF) begin
      errors++;
      $display("FAIL both_rsp1: rsp0v,rsp1v,zero=%b result=%h expected 010 / 00ff",
               {rsp0_valid, rsp1_valid, rsp_zero}, rsp_result);
    end
    rsp1_ready = 1;
    m_last = 1;
    @(negedge clk);
    rsp1_ready = 0;
  endtask

  // Both requesters stay valid; readies held high gives the minimum 3-cycle spacing.
  task automatic test_round_robin();
    int owners[$];
    int times[$];
    int expect_owner;
    @(negedge clk);
    req0_valid = 1; req0_op = 4'd9;  req0_a = 16'h1111; req0_b = 16'h0;
    req1_valid = 1; req1_op = 4'd12; req1_a = 16'h0;    req1_b = 16'h2222;
    rsp0_ready = 1; rsp1_ready = 1;
    expect_owner = 1 - m_last;
    for (int cyc = 0; cyc < 40 && owners.size() < 6; cyc++) begin
      #1;
      if (req0_ready || req1_ready) begin
        owners.push_back(req1_ready ? 1 : 0);
        times.push_back(cyc);
      end
      if (owners.size() < 6) @(negedge clk);
    end
    @(posedge clk);
    req0_valid = 0; req1_valid = 0;
    checks++;
    if (owners.size() != 6) begin
      errors++;
      $display("FAIL rr_count: saw %0d grants, expected 6", owners.size());
    end
    for (int i = 0; i < owners.size(); i++) begin
      checks++;
      if (owners[i] != expect_owner) begin
        errors++;
        $display("FAIL rr_owner[%0d]: got %0d expected %0d", i, owners[i], expect_owner);
      end
      if (i > 0) begin
        checks++;
        if (times[i] - times[i-1] != 3) begin
          errors++;
          $display("FAIL rr_spacing[%0d]: got %0d cycles expected 3", i, times[i] - times[i-1]);
        end
      end
      expect_owner = 1 - expect_owner;
    end
    m_last = 1 - expect_owner;
    @(negedge clk);
    drain("rr");
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    req1_valid = 1; req1_op = 4'b1000; req1_a = 16'h1234; req1_b = 16'h5678;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      errors++;
      $display("FAIL bp_grant: rdy0,rdy1=%b expected 01", {req0_ready, req1_ready});
    end
    @(posedge clk);
    m_last = 1;
    @(negedge clk);
    req1_valid = 0;
    req0_valid = 1; req0_op = 4'd0; req0_a = 16'h0001; req0_b = 16'h0001;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if ({rsp1_valid, rsp0_valid, rsp_zero, req0_ready, busy} !== 5'b10101 || rsp_result !== 16'h0000) begin
        errors++;
        $display("FAIL bp_hold[%0d]: rsp1v,rsp0v,zero,rdy0,busy=%b result=%h expected 10101 / 0000",
                 i, {rsp1_valid, rsp0_valid, rsp_zero, req0_ready, busy}, rsp_result);
      end
    end
    rsp1_ready = 1;
    @(negedge clk);
    rsp1_ready = 0;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: rdy0=%0b busy=%0b expected 1 0", req0_ready, busy);
    end
    req0_valid = 0;  // withdrawn before acceptance: nothing may happen
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_withdraw: busy=%0b expected 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req0_valid = 1; req0_op = 4'd0; req0_a = 16'h0001; req0_b = 16'h0002;
    @(posedge clk);
    @(negedge clk);
    req0_valid = 0;
    rst = 0;
    #1;
    checks++;
    if ({busy, rsp0_valid, rsp1_valid, req0_ready, req1_ready, rsp_zero} !== 6'b0 ||
        {alu_op, alu_first, alu_second, rsp_result} !== '0) begin
      errors++;
      $display("FAIL midrst_clear: ctrl=%b op=%h first=%h second=%h result=%h expected all 0",
               {busy, rsp0_valid, rsp1_valid, req0_ready, req1_ready, rsp_zero},
               alu_op, alu_first, alu_second, rsp_result);
    end
    @(negedge clk);
    rst = 1;
    m_last = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({rsp0_valid, rsp1_valid, busy} !== 3'b000) begin
        errors++;
        $display("FAIL midrst_after[%0d]: rsp0v,rsp1v,busy=%b expected 000", i, {rsp0_valid, rsp1_valid, busy});
      end
    end
  endtask

  task automatic test_wrong_ready();
    @(negedge clk);
    rsp0_ready = 1;
    req1_valid = 1; req1_op = 4'd12; req1_a = 16'h0; req1_b = 16'hABCD;
    @(posedge clk);
    m_last = 1;
    @(negedge clk);
    req1_valid = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({rsp1_valid, rsp0_valid, busy} !== 3'b101 || rsp_result !== 16'hABCD) begin
        errors++;
        $display("FAIL wrong_ready[%0d]: rsp1v,rsp0v,busy=%b result=%h expected 101 / abcd",
                 i, {rsp1_valid, rsp0_valid, busy}, rsp_result);
      end
    end
    rsp0_ready = 0; rsp1_ready = 1;
    @(negedge clk);
    rsp1_ready = 0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wrong_ready_done: busy=%0b expected 0", busy);
    end
  endtask

  // Random traffic: each requester holds a pending request until it is granted.
  task automatic test_random();
    bit           pend [2];
    logic [3:0]   p_op [2];
    logic [W-1:0] p_a  [2];
    logic [W-1:0] p_b  [2];
    logic [W-1:0] exp_res;
    int           g, done, guard, other;
    pend[0] = 0; pend[1] = 0;
    done = 0; guard = 0;
    @(negedge clk);
    while (done < 40 && guard < 400) begin
      guard++;
      for (int n = 0; n < 2; n++) begin
        if (!pend[n] && $urandom_range(0, 9) < 6) begin
          pend[n] = 1;
          p_op[n] = 4'($urandom_range(0, 15));
          p_a[n]  = W'($urandom);
          p_b[n]  = W'($urandom_range(0, 3) == 0 ? p_a[n] : W'($urandom));
        end
      end
      req0_valid = pend[0]; req0_op = p_op[0]; req0_a = p_a[0]; req0_b = p_b[0];
      req1_valid = pend[1]; req1_op = p_op[1]; req1_a = p_a[1]; req1_b = p_b[1];
      #1;
      if (pend[0] && pend[1]) g = 1 - m_last;
      else if (pend[0])       g = 0;
      else if (pend[1])       g = 1;
      else                    g = -1;
      checks++;
      if (req0_ready !== (g == 0) || req1_ready !== (g == 1)) begin
        errors++;
        $display("FAIL rnd_grant: rdy0,rdy1=%b expected grant %0d", {req0_ready, req1_ready}, g);
      end
      @(posedge clk);
      if (g < 0) begin
        @(negedge clk);
        continue;
      end
      other = 1 - g;
      pend[g] = 0;
      m_last = g;
      exp_res = alu_fn(p_op[g], p_a[g], p_b[g]);
      @(negedge clk);
      if (g == 0) req0_valid = 0; else req1_valid = 0;
      checks++;
      if ({alu_op, alu_first, alu_second} !== {p_op[g], p_a[g], p_b[g]} || busy !== 1'b1 ||
          {rsp0_valid, rsp1_valid, req0_ready, req1_ready} !== 4'b0) begin
        errors++;
        $display("FAIL rnd_exec: op=%h first=%h second=%h busy=%0b ctrl=%b expected %h/%h/%h/1/0000",
                 alu_op, alu_first, alu_second, busy, {rsp0_valid, rsp1_valid, req0_ready, req1_ready},
                 p_op[g], p_a[g], p_b[g]);
      end
      for (int d = $urandom_range(0, 3); d >= 0; d--) begin
        @(negedge clk);
        checks++;
        if (rsp0_valid !== (g == 0) || rsp1_valid !== (g == 1) || rsp_result !== exp_res ||
            rsp_zero !== (exp_res == '0) || {req0_ready, req1_ready} !== 2'b00) begin
          errors++;
          $display("FAIL rnd_rsp: owner=%0d rsp0v,rsp1v=%b result=%h zero=%0b expected %h %0b",
                   g, {rsp0_valid, rsp1_valid}, rsp_result, rsp_zero, exp_res, exp_res == '0);
        end
        if (other == 0) rsp0_ready = 1'($urandom_range(0, 1)); else rsp1_ready = 1'($urandom_range(0, 1));
        if (d == 0) begin
          if (g == 0) rsp0_ready = 1; else rsp1_ready = 1;
        end
      end
      @(negedge clk);
      rsp0_ready = 0; rsp1_ready = 0;
      checks++;
      if ({busy, rsp0_valid, rsp1_valid} !== 3'b000) begin
        errors++;
        $display("FAIL rnd_done: busy,rsp0v,rsp1v=%b expected 000", {busy, rsp0_valid, rsp1_valid});
      end
      done++;
    end
    checks++;
    if (done != 40) begin
      errors++;
      $display("FAIL rnd_progress: completed %0d transactions, expected 40", done);
    end
    clear_inputs();
  endtask

  initial begin
    rst = 0;
    clear_inputs();
    test_reset();
    test_single();
    test_both_after_reset();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_wrong_ready();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
